// File: rtl/game_pkg.sv
// game_pkg: shared game-screen state encoding and ASCII helpers.
// Also used by the char_rom_* blocks, so keep the encodings stable.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PLAY  = 2'd2,
        SCORE = 2'd3
    } game_state_t;

    localparam logic [6:0] ASCII_ZERO = 7'h30;

    function automatic logic [6:0] bcd_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {3'b000, digit};
    endfunction

endpackage

// File: rtl/game_flow_ctl_if.sv
// game_flow_ctl_if: bundles the game-flow inputs (vsync, buttons, hits,
// per-screen colours) and its outputs. The controller uses the slave
// modport; whatever drives the inputs uses master.
interface game_flow_ctl_if #(
    parameter int RGB_W        = 12,
    parameter int SCORE_DIGITS = 2
);
    logic                      vsync_in;
    logic                      play_clicked;
    logic                      remote_start;
    logic                      duck_hit;
    logic                      stop_req;
    logic [RGB_W-1:0]          rgb_idle;
    logic [RGB_W-1:0]          rgb_wait;
    logic [RGB_W-1:0]          rgb_game;
    logic [RGB_W-1:0]          rgb_score;

    logic [1:0]                state;
    logic [RGB_W-1:0]          rgb_out;
    logic [4*SCORE_DIGITS-1:0] score_bcd;
    logic [7*SCORE_DIGITS-1:0] score_ascii;
    logic [15:0]               frames_left;
    logic                      spawn_req;
    logic                      game_over;

    modport master (
        output vsync_in, play_clicked, remote_start, duck_hit, stop_req,
        output rgb_idle, rgb_wait, rgb_game, rgb_score,
        input  state, rgb_out, score_bcd, score_ascii, frames_left,
        input  spawn_req, game_over
    );

    modport slave (
        input  vsync_in, play_clicked, remote_start, duck_hit, stop_req,
        input  rgb_idle, rgb_wait, rgb_game, rgb_score,
        output state, rgb_out, score_bcd, score_ascii, frames_left,
        output spawn_req, game_over
    );

endinterface

// File: rtl/game_flow_ctl_bcd_sat_counter.sv
// bcd_sat_counter: multi-digit BCD counter that adds 1 or 2 per enabled
// cycle, rippling the carry digit by digit. Any carry out of the top digit
// pins the value at all nines, so the score never wraps. The ASCII copy is
// registered alongside so both outputs change on the same clock.
module bcd_sat_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc_en,
    input  logic                  inc_two,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   ascii
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] bcd_next;
    logic [7*DIGITS-1:0] ascii_next;
    logic [4:0]          sum;
    logic                carry;

    // Ripple the increment through the digits; overflow saturates to all nines.
    always_comb begin
        bcd_next = bcd;
        sum      = 5'd0;
        carry    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            sum = {1'b0, bcd[4*i +: 4]} +
                  ((i == 0) ? (inc_two ? 5'd2 : 5'd1) : {4'd0, carry});
            if (sum > 5'd9) begin
                bcd_next[4*i +: 4] = 4'(sum - 5'd10);
                carry              = 1'b1;
            end else begin
                bcd_next[4*i +: 4] = sum[3:0];
                carry              = 1'b0;
            end
        end
        if (carry) begin
            bcd_next = ALL_NINES;
        end
    end

    // Per-digit ASCII of the value about to be stored.
    always_comb begin
        ascii_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            ascii_next[7*i +: 7] = bcd_to_ascii(bcd_next[4*i +: 4]);
        end
    end

    // Score register: clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bcd   <= '0;
            ascii <= {DIGITS{ASCII_ZERO}};
        end else if (inc_en) begin
            bcd   <= bcd_next;
            ascii <= ascii_next;
        end
    end

endmodule

// File: rtl/game_flow_ctl.sv
// game_flow_ctl: duck-game screen FSM, frame-based game timer, BCD hit score
// and per-screen RGB selection. Frame ticks come from rising vsync edges.
// Optional macro GAME_COMBO_EN: a hit within COMBO_FRAMES ticks of the
// previous counted hit scores 2 instead of 1.
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int RGB_W        = 12,
    parameter int SCORE_DIGITS = 2,
    parameter int GAME_FRAMES  = 1800,
    parameter int WAIT_TIMEOUT = 0,
    parameter int SCORE_HOLD   = 60,
    parameter int COMBO_FRAMES = 30
) (
    input  logic          pclk,
    input  logic          rst,
    game_flow_ctl_if.slave bus
);

    game_state_t      state_q;
    game_state_t      state_d;
    logic             vs_cur;
    logic             vs_prev;
    logic             stop_cur;
    logic             stop_prev;
    logic             frame_tick;
    logic             stop_rise;
    logic [15:0]      frames_q;
    logic [15:0]      wait_cnt;
    logic [15:0]      hold_cnt;
    logic             enter_play;
    logic             last_tick;
    logic             hit_ok;
    logic             inc_two;
    logic             spawn_q;
    logic             game_over_q;
    logic [RGB_W-1:0] rgb_q;

    assign frame_tick = vs_cur & ~vs_prev;
    assign stop_rise  = stop_cur & ~stop_prev;
    assign hit_ok     = (state_q == PLAY) && bus.duck_hit;
    assign last_tick  = (state_q == PLAY) && frame_tick && (frames_q == 16'd1);

    // Single-register edge detectors for vsync and the stop button.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_cur    <= 1'b0;
            vs_prev   <= 1'b0;
            stop_cur  <= 1'b0;
            stop_prev <= 1'b0;
        end else begin
            vs_cur    <= bus.vsync_in;
            vs_prev   <= vs_cur;
            stop_cur  <= bus.stop_req;
            stop_prev <= stop_cur;
        end
    end

    // Screen state register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enter_play marks the WAIT->PLAY transition cycle.
    always_comb begin
        state_d    = state_q;
        enter_play = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.play_clicked) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.remote_start ||
                    ((WAIT_TIMEOUT > 0) && frame_tick &&
                     (wait_cnt == 16'(WAIT_TIMEOUT - 1)))) begin
                    state_d    = PLAY;
                    enter_play = 1'b1;
                end
            end
            PLAY: begin
                if (last_tick) begin
                    state_d = SCORE;
                end
            end
            SCORE: begin
                if (stop_rise && (hold_cnt >= 16'(SCORE_HOLD))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tick counters for the WAIT auto-start and the SCORE minimum display time.
    always_ff @(posedge pclk) begin
        if (rst) begin
            wait_cnt <= 16'd0;
            hold_cnt <= 16'd0;
        end else begin
            if (state_q != WAIT) begin
                wait_cnt <= 16'd0;
            end else if (frame_tick) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (state_q != SCORE) begin
                hold_cnt <= 16'd0;
            end else if (frame_tick && (hold_cnt < 16'(SCORE_HOLD))) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end

    // Game timer: reload on PLAY entry, count down on ticks, hold elsewhere.
    always_ff @(posedge pclk) begin
        if (rst || enter_play) begin
            frames_q <= 16'(GAME_FRAMES);
        end else if ((state_q == PLAY) && frame_tick && (frames_q != 16'd0)) begin
            frames_q <= frames_q - 16'd1;
        end
    end

    // One-cycle pulses: new target on PLAY entry or counted hit; end of game.
    always_ff @(posedge pclk) begin
        if (rst) begin
            spawn_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            spawn_q     <= enter_play | hit_ok;
            game_over_q <= last_tick;
        end
    end

`ifdef GAME_COMBO_EN
    logic        combo_active;
    logic [15:0] combo_age;

    // Combo window: ticks since the last counted hit, closed after COMBO_FRAMES.
    always_ff @(posedge pclk) begin
        if (rst || enter_play) begin
            combo_active <= 1'b0;
            combo_age    <= 16'd0;
        end else if (hit_ok) begin
            combo_active <= 1'b1;
            combo_age    <= 16'd0;
        end else if (combo_active && frame_tick && (state_q == PLAY)) begin
            if (combo_age == 16'(COMBO_FRAMES)) begin
                combo_active <= 1'b0;
            end else begin
                combo_age <= combo_age + 16'd1;
            end
        end
    end

    assign inc_two = combo_active;
`else
    assign inc_two = 1'b0;
`endif

    bcd_sat_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk     (pclk),
        .rst     (rst),
        .clear   (enter_play),
        .inc_en  (hit_ok),
        .inc_two (inc_two),
        .bcd     (bus.score_bcd),
        .ascii   (bus.score_ascii)
    );

    // Registered per-screen colour select.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            case (state_q)
                IDLE:    rgb_q <= bus.rgb_idle;
                WAIT:    rgb_q <= bus.rgb_wait;
                PLAY:    rgb_q <= bus.rgb_game;
                SCORE:   rgb_q <= bus.rgb_score;
                default: rgb_q <= '0;
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.rgb_out     = rgb_q;
    assign bus.frames_left = frames_q;
    assign bus.spawn_req   = spawn_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// tb_game_flow_ctl: directed self-checking bench for game_flow_ctl with
// GAME_FRAMES=6, WAIT_TIMEOUT=3, SCORE_HOLD=2, COMBO_FRAMES=2.
// Expected score values follow GAME_COMBO_EN when it is defined.
module tb_game_flow_ctl;

    localparam int RGB_W        = 12;
    localparam int SCORE_DIGITS = 2;
    localparam int GAME_FRAMES  = 6;
    localparam int WAIT_TIMEOUT = 3;
    localparam int SCORE_HOLD   = 2;
    localparam int COMBO_FRAMES = 2;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    int   spawn_cnt = 0;
    int   go_cnt    = 0;
    int   spawn_base;
    int   go_base;

    game_flow_ctl_if #(.RGB_W(RGB_W), .SCORE_DIGITS(SCORE_DIGITS)) bus ();

    game_flow_ctl #(
        .RGB_W        (RGB_W),
        .SCORE_DIGITS (SCORE_DIGITS),
        .GAME_FRAMES  (GAME_FRAMES),
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .SCORE_HOLD   (SCORE_HOLD),
        .COMBO_FRAMES (COMBO_FRAMES)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    // 100 MHz pixel clock.
    always #5 pclk = ~pclk;

    // Count output pulses mid-cycle, away from the active edge.
    always @(negedge pclk) begin
        if (bus.spawn_req === 1'b1) spawn_cnt++;
        if (bus.game_over === 1'b1) go_cnt++;
    end

    // Drive one cycle of inputs, then settle just after the edge.
    task automatic applyStimulus(input logic vs, input logic play, input logic remote,
                                 input logic hit, input logic stop);
        bus.vsync_in     = vs;
        bus.play_clicked = play;
        bus.remote_start = remote;
        bus.duck_hit     = hit;
        bus.stop_req     = stop;
        @(posedge pclk);
        #1;
    endtask

    // One vsync rising edge; the tick is acted on by the end of this task.
    task automatic tickFrame(input logic stop);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, stop);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, stop);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        bus.vsync_in     = 1'b0;
        bus.play_clicked = 1'b0;
        bus.remote_start = 1'b0;
        bus.duck_hit     = 1'b0;
        bus.stop_req     = 1'b0;
        bus.rgb_idle     = 12'h111;
        bus.rgb_wait     = 12'h222;
        bus.rgb_game     = 12'h333;
        bus.rgb_score    = 12'h444;

        $display("[TB] reset");
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", 32'(bus.state), 32'd0);
        checkOutput("rst_rgb", 32'(bus.rgb_out), 32'h0);
        checkOutput("rst_score", 32'(bus.score_bcd), 32'h0);
        checkOutput("rst_ascii", 32'(bus.score_ascii), 32'h1830);
        checkOutput("rst_frames", 32'(bus.frames_left), 32'd6);
        checkOutput("rst_spawn", 32'(bus.spawn_req), 32'd0);
        checkOutput("rst_gameover", 32'(bus.game_over), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_rgb", 32'(bus.rgb_out), 32'h111);

        $display("[TB] idle hit, start game");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_hit_score", 32'(bus.score_bcd), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wait_state", 32'(bus.state), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wait_rgb", 32'(bus.rgb_out), 32'h222);
        spawn_base = spawn_cnt;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("play_state", 32'(bus.state), 32'd2);
        checkOutput("play_spawn", 32'(bus.spawn_req), 32'd1);
        checkOutput("play_frames", 32'(bus.frames_left), 32'd6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("play_rgb", 32'(bus.rgb_out), 32'h333);

        $display("[TB] 12 hits");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef GAME_COMBO_EN
        checkOutput("hits12_score", 32'(bus.score_bcd), 32'h23);
        checkOutput("hits12_ascii", 32'(bus.score_ascii), 32'h1933);
`else
        checkOutput("hits12_score", 32'(bus.score_bcd), 32'h12);
        checkOutput("hits12_ascii", 32'(bus.score_ascii), 32'h18B2);
`endif
        checkOutput("hits12_spawns", 32'(spawn_cnt - spawn_base), 32'd13);

        $display("[TB] 105 hits, saturation");
        for (int i = 0; i < 105; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("sat_score", 32'(bus.score_bcd), 32'h99);
        checkOutput("sat_ascii", 32'(bus.score_ascii), 32'h1CB9);

        $display("[TB] timer runs out with stop held");
        go_base = go_cnt;
        tickFrame(1'b1);
        checkOutput("tick1_frames", 32'(bus.frames_left), 32'd5);
        for (int i = 0; i < 5; i++) begin
            tickFrame(1'b1);
        end
        checkOutput("end_state", 32'(bus.state), 32'd3);
        checkOutput("end_frames", 32'(bus.frames_left), 32'd0);
        checkOutput("end_gameover", 32'(bus.game_over), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("gameover_once", 32'(go_cnt - go_base), 32'd1);
        checkOutput("gameover_low", 32'(bus.game_over), 32'd0);
        checkOutput("score_rgb", 32'(bus.rgb_out), 32'h444);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("held_stay", 32'(bus.state), 32'd3);

        $display("[TB] early press, hold, release, press");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("early_press_stay", 32'(bus.state), 32'd3);
        tickFrame(1'b1);
        tickFrame(1'b1);
        checkOutput("held_ticks_stay", 32'(bus.state), 32'd3);
        checkOutput("score_frames_hold", 32'(bus.frames_left), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stop_to_idle", 32'(bus.state), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_hit_keep", 32'(bus.score_bcd), 32'h99);

        $display("[TB] WAIT timeout");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tickFrame(1'b0);
        tickFrame(1'b0);
        checkOutput("timeout_wait", 32'(bus.state), 32'd1);
        tickFrame(1'b0);
        checkOutput("timeout_play", 32'(bus.state), 32'd2);
        checkOutput("timeout_score_clr", 32'(bus.score_bcd), 32'h0);
        checkOutput("timeout_frames", 32'(bus.frames_left), 32'd6);

        $display("[TB] hit spacing");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("space_hit1", 32'(bus.score_bcd), 32'h1);
        tickFrame(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef GAME_COMBO_EN
        checkOutput("space_hit2", 32'(bus.score_bcd), 32'h3);
`else
        checkOutput("space_hit2", 32'(bus.score_bcd), 32'h2);
`endif
        tickFrame(1'b0);
        tickFrame(1'b0);
        tickFrame(1'b0);
        checkOutput("space_frames", 32'(bus.frames_left), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef GAME_COMBO_EN
        checkOutput("space_hit3", 32'(bus.score_bcd), 32'h4);
`else
        checkOutput("space_hit3", 32'(bus.score_bcd), 32'h3);
`endif

        $display("[TB] reset mid-PLAY");
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_state", 32'(bus.state), 32'd0);
        checkOutput("midrst_score", 32'(bus.score_bcd), 32'h0);
        checkOutput("midrst_rgb", 32'(bus.rgb_out), 32'h0);
        checkOutput("midrst_frames", 32'(bus.frames_left), 32'd6);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("postrst_rgb", 32'(bus.rgb_out), 32'h111);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/game_flow_ctl.md
Name: game_flow_ctl

Overview:
Parametrised successor of the duck-game flow logic: one block owns the screen state machine, frame-based game timer, BCD hit score and per-screen RGB selection. Sits after the per-screen char/image renderers and before sync_delay; replaces the separate state machine, score counter and score-to-ASCII path. Frame timing is derived from the vsync of the timing chain, so game length is set in frames, not in clock cycles.

Parameters:
RGB_W, 12, width of each colour bus
SCORE_DIGITS, 2, number of BCD score digits (1..4)
GAME_FRAMES, 1800, length of the PLAY state in frames (min 1)
WAIT_TIMEOUT, 0, frames in WAIT before auto-start; 0 means wait forever for remote_start
SCORE_HOLD, 60, frames SCORE must be shown before stop_req is accepted
COMBO_FRAMES, 30, combo window in frames (used only with the optional feature)

Ports:
pclk  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
vsync_in  in  1  vsync from the timing chain; its rising edge marks a frame tick
play_clicked  in  1  one-cycle pulse; PLAY button hit
remote_start  in  1  level; opponent ready (UART)
duck_hit  in  1  one-cycle pulse; target hit
stop_req  in  1  level; mouse left button
rgb_idle, rgb_wait, rgb_game, rgb_score  in  RGB_W each  per-screen pixel colour
state  out  2  0 IDLE, 1 WAIT, 2 PLAY, 3 SCORE
rgb_out  out  RGB_W  selected pixel, registered
score_bcd  out  4*SCORE_DIGITS  score, digit 0 in LSBs
score_ascii  out  7*SCORE_DIGITS  per-digit ASCII code, 7'h30 + digit
frames_left  out  16  remaining PLAY frames
spawn_req  out  1  one-cycle pulse requesting a new target position
game_over  out  1  one-cycle pulse on PLAY->SCORE

Behaviour:
- Reset: state=IDLE, rgb_out=0, score_bcd=0, score_ascii all 7'h30, frames_left=GAME_FRAMES, spawn_req=0, game_over=0, all counters and edge registers cleared. Reset in any state aborts at once.
- frame_tick: vsync_in registered once; tick = cur & ~prev, one cycle wide, one cycle after the edge. stop_req is edge-detected the same way.
- IDLE -> WAIT on play_clicked.
- WAIT -> PLAY on remote_start, or when WAIT_TIMEOUT>0 and WAIT_TIMEOUT ticks have passed. On entry to PLAY: score cleared, frames_left=GAME_FRAMES, spawn_req pulses.
- PLAY: each tick decrements frames_left. A tick that takes frames_left from 1 to 0 moves the state to SCORE next cycle and pulses game_over.
- SCORE -> IDLE on a stop_req rising edge, accepted only after SCORE_HOLD ticks in SCORE. A button held across entry does not exit SCORE.
- duck_hit counts only while state==PLAY. If it arrives in the same cycle as the final tick it still counts. Each counted hit pulses spawn_req next cycle.
- Score: BCD ripple increment. Saturates at all nines (99 for 2 digits) and never wraps.
- score_ascii is registered with the same update cycle as score_bcd.
- rgb_out = registered mux(state) of the four rgb inputs, 1-cycle latency; value 0 when rst.
- frames_left holds its value in SCORE and reloads on PLAY entry.

Optional Feature:
GAME_COMBO_EN
- Defined: a hit within COMBO_FRAMES ticks of the previous counted hit adds 2 (BCD, saturating); otherwise it adds 1. The combo window resets on PLAY entry.
- Undefined: every hit adds 1 and the combo counter is not synthesised.

Decomposition:
- game_pkg: state enum (IDLE/WAIT/PLAY/SCORE) and the ASCII_ZERO=7'h30 constant, shared with the char_rom_* blocks.
- Sub-module bcd_sat_counter (SCORE_DIGITS, increment of 1 or 2, clear, saturation); instantiated once here.

Test Plan:
- GAME_FRAMES=4, WAIT_TIMEOUT=0: play_clicked, remote_start, then 4 vsync edges -> state 0→1→2→3; game_over pulses once; frames_left=0.
- In PLAY, 12 duck_hit pulses -> score_bcd=8'h12, score_ascii={7'h31,7'h32}, 12 spawn_req pulses plus 1 at PLAY entry.
- 105 hits with SCORE_DIGITS=2 -> score_bcd stays 8'h99; a hit during IDLE leaves the score unchanged.
- SCORE_HOLD=2, stop_req held high through PLAY->SCORE -> remains in SCORE. Release, then press after 2 ticks -> IDLE.
- WAIT_TIMEOUT=3, no remote_start -> PLAY after 3rd tick. Assert rst mid-PLAY -> next cycle state=0, score=0, rgb_out=0.
- GAME_COMBO_EN, COMBO_FRAMES=2: hits at ticks 0, 1, 5 -> score 1, 3, 4.
